// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage: FSM state encoding,
// default cache geometry and word-alignment helpers.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } mem_state_t;

   localparam int LINES_DEF = 16;
   localparam int WORD_LSB  = 2;
   localparam int IDX_W     = $clog2(LINES_DEF);
   localparam int TAG_W     = 32 - IDX_W - WORD_LSB;

   localparam logic [1:0] WORD_OFS = 2'b00;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:WORD_LSB], WORD_OFS};
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Backing-memory request/ack bus between the MEM stage (master) and
// the external memory model or controller (slave).
interface mem_stage_if;

   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [31:0] memRdata;
   logic        memAck;

   modport master (
      output memReq, memWe, memAddr, memWdata,
      input  memRdata, memAck
   );

   modport slave (
      input  memReq, memWe, memAddr, memWdata,
      output memRdata, memAck
   );

endinterface

// File: rtl/dcache_array.sv
// Direct-mapped data cache storage: async read with hit compare, one sync
// write port for fills and store updates, async clear of valid bits.
module dcache_array
   import mem_pkg::*;
#(
   parameter int LINES = LINES_DEF,
   parameter int IW    = IDX_W,
   parameter int TW    = TAG_W
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [IW-1:0] idx,
   input  logic [TW-1:0] tag,
   output logic          hit,
   output logic [31:0]   rd_data,
   input  logic          wr_en,
   input  logic [31:0]   wr_data
);

   logic [LINES-1:0] valid;
   logic [TW-1:0]    tags  [LINES];
   logic [31:0]      words [LINES];

   // Valid bits: cleared asynchronously, set on any write to the line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[idx] <= 1'b1;
      end
   end

   // Tag and data storage; a store hit rewrites the same tag it matched
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[idx]  <= tag;
         words[idx] <= wr_data;
      end
   end

   assign hit     = valid[idx] && (tags[idx] == tag);
   assign rd_data = words[idx];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RISC-V pipeline: branch/jump resolution, write-through
// data cache with miss FSM, and the MEM/WB register. Optional: DCACHE_STATS_EN.
module mem_stage
   import mem_pkg::*;
#(
   parameter int LINES  = LINES_DEF,
   parameter int ADDR_W = 32
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] rs2,
   input  logic [31:0] immPc,
   input  logic [31:0] pcAdd4,
   input  logic [31:0] outAlu,
   input  logic [4:0]  rd,
   input  logic        EscReg,
   input  logic        EscMem,
   input  logic        jump,
   input  logic        blt,
   input  logic        bge,
   input  logic        jalr,
   input  logic        lw,
   output logic        pcSrc,
   output logic [31:0] pcTarget,
   output logic        flush,
   output logic        stall,
   mem_stage_if.master bus,
   output logic [31:0] wbData,
   output logic [4:0]  wbRd,
   output logic        wbEscReg
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hitCount,
   output logic [31:0] missCount
`endif
);

   localparam int IW = $clog2(LINES);
   localparam int TW = ADDR_W - IW - WORD_LSB;

   mem_state_t    state;
   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic          hit;
   logic [31:0]   cache_data;
   logic          cache_we;
   logic [31:0]   cache_wdata;
   logic          store_req;
   logic          load_req;
   logic          br_taken;
   logic          redirect;
   logic [31:0]   load_data;
   logic [31:0]   wb_next;

   assign idx       = outAlu[IW+WORD_LSB-1:WORD_LSB];
   assign tag       = outAlu[ADDR_W-1:IW+WORD_LSB];
   assign store_req = EscMem;
   assign load_req  = lw & ~EscMem;

   dcache_array #(
      .LINES (LINES),
      .IW    (IW),
      .TW    (TW)
   ) u_dcache (
      .clk     (clk),
      .rst_n   (reset),
      .idx     (idx),
      .tag     (tag),
      .hit     (hit),
      .rd_data (cache_data),
      .wr_en   (cache_we),
      .wr_data (cache_wdata)
   );

   // Store hits update the line on the edge that enters WR_THRU; fills land on the ack edge
   always_comb begin
      cache_we    = 1'b0;
      cache_wdata = rs2;
      case (state)
         IDLE: begin
            cache_we    = store_req & hit;
            cache_wdata = rs2;
         end
         RD_MISS: begin
            cache_we    = bus.memAck;
            cache_wdata = bus.memRdata;
         end
         default: begin
            cache_we    = 1'b0;
            cache_wdata = rs2;
         end
      endcase
   end

   // Stall: new store or load miss in IDLE, or an outstanding request not yet acked
   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:             stall = store_req | (load_req & ~hit);
         RD_MISS, WR_THRU: stall = ~bus.memAck;
         default:          stall = 1'b0;
      endcase
   end

   // Redirect target with jalr > jump > branch priority
   always_comb begin
      br_taken = (blt & outAlu[0]) | (bge & ~outAlu[0]);
      redirect = jalr | jump | br_taken;
      if (jalr) begin
         pcTarget = {outAlu[31:1], 1'b0};
      end else begin
         pcTarget = immPc;
      end
   end

   assign pcSrc = redirect & ~stall;
   assign flush = pcSrc;

   // Writeback data select; during RD_MISS the only load data is the returning word
   always_comb begin
      if (state == RD_MISS) begin
         load_data = bus.memRdata;
      end else begin
         load_data = cache_data;
      end
      if (load_req) begin
         wb_next = load_data;
      end else if (jump | jalr) begin
         wb_next = pcAdd4;
      end else begin
         wb_next = outAlu;
      end
   end

   // Miss / write-through FSM with registered memory-bus outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         bus.memReq   <= 1'b0;
         bus.memWe    <= 1'b0;
         bus.memAddr  <= 32'h0000_0000;
         bus.memWdata <= 32'h0000_0000;
      end else begin
         case (state)
            IDLE: begin
               if (store_req) begin
                  state        <= WR_THRU;
                  bus.memReq   <= 1'b1;
                  bus.memWe    <= 1'b1;
                  bus.memAddr  <= word_align(outAlu);
                  bus.memWdata <= rs2;
               end else if (load_req && !hit) begin
                  state        <= RD_MISS;
                  bus.memReq   <= 1'b1;
                  bus.memWe    <= 1'b0;
                  bus.memAddr  <= word_align(outAlu);
                  bus.memWdata <= 32'h0000_0000;
               end else begin
                  bus.memReq <= 1'b0;
                  bus.memWe  <= 1'b0;
               end
            end
            RD_MISS, WR_THRU: begin
               if (bus.memAck) begin
                  state      <= IDLE;
                  bus.memReq <= 1'b0;
                  bus.memWe  <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               bus.memReq <= 1'b0;
               bus.memWe  <= 1'b0;
            end
         endcase
      end
   end

   // MEM/WB register; a stall inserts a bubble by dropping only the write enable
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wbData   <= 32'h0000_0000;
         wbRd     <= 5'd0;
         wbEscReg <= 1'b0;
      end else if (stall) begin
         wbEscReg <= 1'b0;
      end else begin
         wbData   <= wb_next;
         wbRd     <= rd;
         wbEscReg <= EscReg & ~EscMem;
      end
   end

`ifdef DCACHE_STATS_EN
   // Hit/miss statistics, free-running and wrapping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hitCount  <= 32'd0;
         missCount <= 32'd0;
      end else if (state == IDLE && load_req) begin
         if (hit) begin
            hitCount <= hitCount + 32'd1;
         end else begin
            missCount <= missCount + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: cache miss/hit, write-through,
// no-write-allocate, redirects, reset mid-miss and index aliasing.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic [31:0] rs2, immPc, pcAdd4, outAlu;
   logic [4:0]  rd;
   logic        EscReg, EscMem, jump, blt, bge, jalr, lw;
   logic        pcSrc, flush, stall;
   logic [31:0] pcTarget;
   logic [31:0] wbData;
   logic [4:0]  wbRd;
   logic        wbEscReg;
`ifdef DCACHE_STATS_EN
   logic [31:0] hitCount, missCount;
`endif

   int vectors    = 0;
   int miscompares = 0;

   mem_stage_if bus ();

   mem_stage dut (
      .clk      (clk),
      .reset    (reset),
      .rs2      (rs2),
      .immPc    (immPc),
      .pcAdd4   (pcAdd4),
      .outAlu   (outAlu),
      .rd       (rd),
      .EscReg   (EscReg),
      .EscMem   (EscMem),
      .jump     (jump),
      .blt      (blt),
      .bge      (bge),
      .jalr     (jalr),
      .lw       (lw),
      .pcSrc    (pcSrc),
      .pcTarget (pcTarget),
      .flush    (flush),
      .stall    (stall),
      .bus      (bus),
      .wbData   (wbData),
      .wbRd     (wbRd),
      .wbEscReg (wbEscReg)
`ifdef DCACHE_STATS_EN
      ,
      .hitCount  (hitCount),
      .missCount (missCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      rs2 = 32'h0; immPc = 32'h0; pcAdd4 = 32'h0; outAlu = 32'h0; rd = 5'd0;
      EscReg = 1'b0; EscMem = 1'b0; jump = 1'b0; blt = 1'b0; bge = 1'b0;
      jalr = 1'b0; lw = 1'b0;
      bus.memAck = 1'b0; bus.memRdata = 32'h0;
   endtask

   task automatic ack(input logic [31:0] d);
      bus.memAck = 1'b1; bus.memRdata = d;
      step();
      bus.memAck = 1'b0; bus.memRdata = 32'h0;
   endtask

   task automatic test_reset();
      #12;
      vectors++; if (wbData !== 32'h0) begin miscompares++; $display("FAIL rst_wbData: got %h want 0", wbData); end
      vectors++; if (wbRd !== 5'd0) begin miscompares++; $display("FAIL rst_wbRd: got %0d want 0", wbRd); end
      vectors++; if (wbEscReg !== 1'b0) begin miscompares++; $display("FAIL rst_wbEscReg: got %b want 0", wbEscReg); end
      vectors++; if (bus.memReq !== 1'b0 || bus.memWe !== 1'b0) begin miscompares++; $display("FAIL rst_memReq: got req=%b we=%b want 0/0", bus.memReq, bus.memWe); end
      vectors++; if (bus.memAddr !== 32'h0 || bus.memWdata !== 32'h0) begin miscompares++; $display("FAIL rst_memBus: got addr=%h wdata=%h want 0/0", bus.memAddr, bus.memWdata); end
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_read_miss();
      clear_ctl(); lw = 1'b1; outAlu = 32'h40; rd = 5'd5; EscReg = 1'b1;
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rm_stall1: got %b want 1", stall); end
      step();
      vectors++; if (bus.memReq !== 1'b1 || bus.memWe !== 1'b0) begin miscompares++; $display("FAIL rm_req: got req=%b we=%b want 1/0", bus.memReq, bus.memWe); end
      vectors++; if (bus.memAddr !== 32'h40) begin miscompares++; $display("FAIL rm_addr: got %h want 00000040", bus.memAddr); end
      vectors++; if (stall !== 1'b1 || wbEscReg !== 1'b0) begin miscompares++; $display("FAIL rm_stall2: got stall=%b wbEscReg=%b want 1/0", stall, wbEscReg); end
      step();
      vectors++; if (stall !== 1'b1 || bus.memReq !== 1'b1) begin miscompares++; $display("FAIL rm_stall3: got stall=%b req=%b want 1/1", stall, bus.memReq); end
      bus.memAck = 1'b1; bus.memRdata = 32'hDEAD_BEEF;
      #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rm_ackstall: got %b want 0", stall); end
      step();
      bus.memAck = 1'b0; bus.memRdata = 32'h0;
      vectors++; if (wbData !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rm_wbData: got %h want deadbeef", wbData); end
      vectors++; if (wbEscReg !== 1'b1 || wbRd !== 5'd5) begin miscompares++; $display("FAIL rm_wbCtl: got en=%b rd=%0d want 1/5", wbEscReg, wbRd); end
      vectors++; if (bus.memReq !== 1'b0) begin miscompares++; $display("FAIL rm_reqdone: got %b want 0", bus.memReq); end
      rd = 5'd6;
      #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rh_stall: got %b want 0", stall); end
      step();
      vectors++; if (wbData !== 32'hDEAD_BEEF || wbRd !== 5'd6) begin miscompares++; $display("FAIL rh_wb: got %h rd=%0d want deadbeef/6", wbData, wbRd); end
   endtask

   task automatic test_store_hit();
      clear_ctl(); EscMem = 1'b1; EscReg = 1'b1; outAlu = 32'h40; rs2 = 32'h1234_5678; rd = 5'd9;
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL sh_stall1: got %b want 1", stall); end
      step();
      vectors++; if (bus.memReq !== 1'b1 || bus.memWe !== 1'b1) begin miscompares++; $display("FAIL sh_req: got req=%b we=%b want 1/1", bus.memReq, bus.memWe); end
      vectors++; if (bus.memAddr !== 32'h40 || bus.memWdata !== 32'h1234_5678) begin miscompares++; $display("FAIL sh_bus: got %h/%h want 00000040/12345678", bus.memAddr, bus.memWdata); end
      vectors++; if (wbEscReg !== 1'b0) begin miscompares++; $display("FAIL sh_bubble: got %b want 0", wbEscReg); end
      step();
      vectors++; if (stall !== 1'b1 || bus.memWe !== 1'b1) begin miscompares++; $display("FAIL sh_hold: got stall=%b we=%b want 1/1", stall, bus.memWe); end
      bus.memAck = 1'b1;
      #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL sh_ackstall: got %b want 0", stall); end
      step();
      bus.memAck = 1'b0;
      vectors++; if (wbEscReg !== 1'b0 || bus.memReq !== 1'b0) begin miscompares++; $display("FAIL sh_done: got en=%b req=%b want 0/0", wbEscReg, bus.memReq); end
      clear_ctl(); lw = 1'b1; outAlu = 32'h40; rd = 5'd7; EscReg = 1'b1;
      #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL sh_lwhit: got stall=%b want 0", stall); end
      step();
      vectors++; if (wbData !== 32'h1234_5678 || wbEscReg !== 1'b1) begin miscompares++; $display("FAIL sh_lwdata: got %h en=%b want 12345678/1", wbData, wbEscReg); end
   endtask

   task automatic test_no_write_allocate();
      clear_ctl(); EscMem = 1'b1; outAlu = 32'h80; rs2 = 32'hAAAA_5555;
      step();
      ack(32'h0);
      clear_ctl(); lw = 1'b1; outAlu = 32'h80; EscReg = 1'b1; rd = 5'd3;
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL nwa_stall: got %b want 1", stall); end
      step();
      vectors++; if (bus.memReq !== 1'b1 || bus.memWe !== 1'b0 || bus.memAddr !== 32'h80) begin miscompares++; $display("FAIL nwa_req: got req=%b we=%b addr=%h want 1/0/00000080", bus.memReq, bus.memWe, bus.memAddr); end
      ack(32'h0BAD_F00D);
      vectors++; if (wbData !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL nwa_wbData: got %h want 0badf00d", wbData); end
   endtask

   task automatic test_redirect();
      clear_ctl(); blt = 1'b1; outAlu = 32'h1; immPc = 32'h100;
      #1;
      vectors++; if (pcSrc !== 1'b1 || flush !== 1'b1 || pcTarget !== 32'h100) begin miscompares++; $display("FAIL br_blt: got src=%b fl=%b tgt=%h want 1/1/00000100", pcSrc, flush, pcTarget); end
      blt = 1'b0; bge = 1'b1;
      #1;
      vectors++; if (pcSrc !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL br_bge_nt: got src=%b fl=%b want 0/0", pcSrc, flush); end
      outAlu = 32'h0;
      #1;
      vectors++; if (pcSrc !== 1'b1) begin miscompares++; $display("FAIL br_bge_t: got %b want 1", pcSrc); end
      bge = 1'b0; jump = 1'b1; immPc = 32'h300;
      #1;
      vectors++; if (pcSrc !== 1'b1 || pcTarget !== 32'h300) begin miscompares++; $display("FAIL br_jump: got src=%b tgt=%h want 1/00000300", pcSrc, pcTarget); end
      jalr = 1'b1; outAlu = 32'h203; pcAdd4 = 32'h1004; rd = 5'd1; EscReg = 1'b1;
      #1;
      vectors++; if (pcTarget !== 32'h202) begin miscompares++; $display("FAIL br_jalr: got %h want 00000202", pcTarget); end
      step();
      vectors++; if (wbData !== 32'h1004 || wbRd !== 5'd1 || wbEscReg !== 1'b1) begin miscompares++; $display("FAIL br_link: got %h rd=%0d en=%b want 00001004/1/1", wbData, wbRd, wbEscReg); end
      clear_ctl(); outAlu = 32'h55; EscReg = 1'b1; rd = 5'd2;
      step();
      vectors++; if (wbData !== 32'h55) begin miscompares++; $display("FAIL alu_wb: got %h want 00000055", wbData); end
      clear_ctl(); EscMem = 1'b1; blt = 1'b1; outAlu = 32'h1; immPc = 32'h100;
      #1;
      vectors++; if (stall !== 1'b1 || pcSrc !== 1'b0) begin miscompares++; $display("FAIL br_stallmask: got stall=%b src=%b want 1/0", stall, pcSrc); end
      step();
      vectors++; if (wbData !== 32'h55 || wbEscReg !== 1'b0) begin miscompares++; $display("FAIL wb_hold: got %h en=%b want 00000055/0", wbData, wbEscReg); end
      ack(32'h0);
      clear_ctl();
      step();
   endtask

   task automatic test_reset_mid_miss();
      clear_ctl(); lw = 1'b1; outAlu = 32'h40; EscReg = 1'b1;
      step();
      ack(32'h5555_AAAA);
      #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rr_prehit: got stall=%b want 0", stall); end
      outAlu = 32'h144; rd = 5'd4;
      step();
      vectors++; if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h144) begin miscompares++; $display("FAIL rr_req: got req=%b addr=%h want 1/00000144", bus.memReq, bus.memAddr); end
      #2 reset = 1'b0;
      #1;
      vectors++; if (bus.memReq !== 1'b0 || bus.memWe !== 1'b0 || bus.memAddr !== 32'h0 || bus.memWdata !== 32'h0) begin miscompares++; $display("FAIL rr_bus: got req=%b we=%b addr=%h wd=%h want all 0", bus.memReq, bus.memWe, bus.memAddr, bus.memWdata); end
      vectors++; if (wbData !== 32'h0 || wbRd !== 5'd0 || wbEscReg !== 1'b0) begin miscompares++; $display("FAIL rr_wb: got %h rd=%0d en=%b want 0/0/0", wbData, wbRd, wbEscReg); end
      clear_ctl();
      step();
      reset = 1'b1;
      step();
      ack(32'hFFFF_FFFF);
      vectors++; if (bus.memReq !== 1'b0 || wbData !== 32'h0 || wbEscReg !== 1'b0) begin miscompares++; $display("FAIL rr_lateack: got req=%b wb=%h en=%b want 0/0/0", bus.memReq, wbData, wbEscReg); end
      lw = 1'b1; outAlu = 32'h40; EscReg = 1'b1; rd = 5'd8;
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rr_coldmiss: got stall=%b want 1", stall); end
      step();
      vectors++; if (bus.memReq !== 1'b1 || bus.memAddr !== 32'h40) begin miscompares++; $display("FAIL rr_refill: got req=%b addr=%h want 1/00000040", bus.memReq, bus.memAddr); end
      ack(32'h1111_2222);
      vectors++; if (wbData !== 32'h1111_2222 || wbRd !== 5'd8) begin miscompares++; $display("FAIL rr_wbData: got %h rd=%0d want 11112222/8", wbData, wbRd); end
   endtask

   task automatic test_aliasing();
      clear_ctl(); lw = 1'b1; outAlu = 32'h00; EscReg = 1'b1; rd = 5'd10;
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL al_miss0: got stall=%b want 1", stall); end
      step();
      vectors++; if (bus.memAddr !== 32'h0 || bus.memReq !== 1'b1) begin miscompares++; $display("FAIL al_addr0: got %h req=%b want 0/1", bus.memAddr, bus.memReq); end
      ack(32'hA0A0_A0A0);
      vectors++; if (wbData !== 32'hA0A0_A0A0) begin miscompares++; $display("FAIL al_wb0: got %h want a0a0a0a0", wbData); end
      outAlu = 32'h40;
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL al_miss40: got stall=%b want 1", stall); end
      step();
      ack(32'hB0B0_B0B0);
      vectors++; if (wbData !== 32'hB0B0_B0B0) begin miscompares++; $display("FAIL al_wb40: got %h want b0b0b0b0", wbData); end
      outAlu = 32'h00;
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL al_evict: got stall=%b want 1", stall); end
      step();
      ack(32'hC0C0_C0C0);
      vectors++; if (wbData !== 32'hC0C0_C0C0) begin miscompares++; $display("FAIL al_wb0b: got %h want c0c0c0c0", wbData); end
      clear_ctl();
      step();
   endtask

   initial begin
      reset = 1'b0;
      clear_ctl();
      test_reset();
      test_read_miss();
      test_store_hit();
      test_no_write_allocate();
      test_redirect();
      test_reset_mid_miss();
      test_aliasing();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM register outputs and resolves jumps and branches, producing the PC redirect and the flush.
- It services lw/sw through an internal direct-mapped, write-through data cache. A miss or write-through raises a pipeline stall.
- It owns the MEM/WB register and drives the writeback data, rd and register-write enable.

Parameters:
LINES, 16, number of cache lines (one 32-bit word per line, power of 2)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
rs2  in  32  store data
immPc  in  32  PC+imm target (jal/branch)
pcAdd4  in  32  link value
outAlu  in  32  ALU result: memory address, jalr target, or compare result in bit 0 for blt/bge
rd  in  5  destination register
EscReg, EscMem, jump, blt, bge, jalr, lw  in  1 each  control flags from EX/MEM
pcSrc  out  1  redirect PC (combinational)
pcTarget  out  32  redirect target (combinational)
flush  out  1  flush IF/ID, ID/EX and EX/MEM (combinational, equals pcSrc)
stall  out  1  freeze PC and all upstream pipeline registers (combinational)
memReq  out  1  backing-memory request
memWe  out  1  1 = write request
memAddr  out  32  word-aligned address (bits [1:0] = 0)
memWdata  out  32  write data
memRdata  in  32  read data, valid with memAck
memAck  in  1  single-cycle completion pulse
wbData  out  32  MEM/WB writeback data (registered)
wbRd  out  5  MEM/WB rd (registered)
wbEscReg  out  1  MEM/WB register-write enable (registered)

Behaviour:
- Reset (reset=0, asynchronous):
  - wbData = 0, wbRd = 0, wbEscReg = 0.
  - FSM goes to IDLE; memReq = 0, memWe = 0; memAddr and memWdata are 0.
  - All cache valid bits are cleared.
  - Reset mid-miss abandons the request; a late memAck arriving after reset is ignored.
- Address decode: idx = outAlu[log2(LINES)+1:2], tag = outAlu[31:log2(LINES)+2]. Bits [1:0] are ignored; accesses are word only.
- Redirect priority is jalr > jump > branch:
  - jalr: pcTarget = outAlu & ~1.
  - jump: pcTarget = immPc.
  - blt taken when outAlu[0] = 1; bge taken when outAlu[0] = 0.
  - pcSrc is 1 on any taken redirect. pcSrc is forced to 0 while stall = 1.
- FSM states IDLE, RD_MISS, WR_THRU:
  - IDLE, lw hit: no stall; the cached data is registered into MEM/WB at the next edge. Added latency is 0.
  - IDLE, lw miss: stall = 1 combinationally. Go to RD_MISS; memReq = 1, memWe = 0, memAddr = {outAlu[31:2], 2'b00}.
  - IDLE, EscMem: stall = 1. Go to WR_THRU; memReq = 1, memWe = 1, memWdata = rs2.
    - On a hit the line data is updated at the same edge.
    - On a miss nothing is allocated (no-write-allocate).
  - RD_MISS or WR_THRU: memReq, memWe, memAddr and memWdata are held stable until memAck.
    - stall = !memAck.
    - On the memAck edge, RD_MISS fills the line (valid = 1, tag, data = memRdata) and registers memRdata into wbData.
    - Both states then return to IDLE.
  - The inputs are guaranteed stable while stall = 1, because the upstream registers are frozen.
- If lw and EscMem are both set, the store takes precedence and the lw flag is ignored.
- MEM/WB register, updated on the edges when stall = 0:
  - wbData = lw ? load data : (jump | jalr) ? pcAdd4 : outAlu.
  - wbRd = rd; wbEscReg = EscReg & ~EscMem.
- While stall = 1, MEM/WB takes a bubble: wbEscReg = 0 and the other MEM/WB values are held.
- A memAck seen in IDLE is ignored.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, add two outputs:
  - hitCount (32): increments on each lw hit in IDLE.
  - missCount (32): increments on each RD_MISS entry.
  - Both are cleared by reset and wrap at 2^32.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg holds:
  - the FSM state typedef (IDLE, RD_MISS, WR_THRU);
  - the LINES default;
  - derived IDX_W and TAG_W;
  - word-align constants.
- One sub-module, dcache_array: valid/tag/data storage.
  - Asynchronous read with hit compare.
  - Synchronous write port for fill or store update.
  - Asynchronous active-low clear of the valid bits.

Test Plan:
- lw to 0x40 on a cold cache, memAck after 3 cycles with memRdata = 0xDEADBEEF:
  - stall is high for 3 cycles and memAddr = 0x40.
  - wbData = 0xDEADBEEF and wbEscReg = 1 after the ack edge.
  - A second lw to 0x40 completes with no stall and the same wbData.
- sw rs2 = 0x12345678 to 0x40 (line hit), then lw 0x40:
  - memWe = 1 and stall holds until memAck.
  - The lw hits with wbData = 0x12345678.
  - wbEscReg = 0 during the store.
- sw to 0x80 on a miss, then lw 0x80 → RD_MISS is issued, confirming no-write-allocate.
- Redirects:
  - blt with outAlu = 1, immPc = 0x100 → pcSrc = flush = 1, pcTarget = 0x100.
  - bge with outAlu = 1 → pcSrc = 0.
  - jalr with outAlu = 0x203 → pcTarget = 0x202, wbData = pcAdd4.
- reset driven low while in RD_MISS, then a late memAck:
  - memReq = 0, all outputs are 0 and the FSM is in IDLE.
  - The ack is ignored; a following lw 0x40 misses.
- Aliasing: lw 0x00 then lw 0x40 with LINES = 16 (same index, different tag) → both miss and the second access evicts the first.
